// File: rtl/accel_sample_feeder.sv
// rtl/accel_sample_feeder.sv - assembles X/Y/Z words, removes zero-g offset, times dt, feeds the Integrator
// Completed frames pass through one register stage, then a one-deep pending buffer that issues when !bussy.
module accel_sample_feeder #(
  parameter int TICK_DIV = 1000,
  parameter int CAL_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        frame_start,
  input  logic        cal_start,
  input  logic        bussy,
  output logic [15:0] acx,
  output logic [15:0] acy,
  output logic [15:0] acz,
  output logic [15:0] dt,
  output logic        enable,
  output logic        cal_done,
  output logic        overrun
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = 16 + CAL_LOG2;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_CAL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]          r_cnt;
  logic [39:0]         r_buf;
  logic                r_done;
  logic [15:0]         r_raw_x, r_raw_y, r_raw_z;
  logic [PW-1:0]       r_pre;
  logic [15:0]         r_dt_cnt;
  logic [AW-1:0]       r_acc_x, r_acc_y, r_acc_z;
  logic [CAL_LOG2-1:0] r_cal_cnt;
  logic [15:0]         r_off_x, r_off_y, r_off_z;
  logic                r_pend_valid;
  logic [15:0]         r_pend_x, r_pend_y, r_pend_z, r_pend_dt;

  logic                w_byte_done;
  logic                w_take;
  logic                w_cal_frame;
  logic                w_cal_last;
  logic                w_issue;
  logic [15:0]         w_cor_x, w_cor_y, w_cor_z;
  logic [AW-1:0]       w_acc_x_next, w_acc_y_next, w_acc_z_next;

  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] d;
    d = {a[15], a} - {b[15], b};
    if (d[16] != d[15]) return d[16] ? 16'h8000 : 16'h7FFF;
    return d[15:0];
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign w_byte_done = byte_valid & ~frame_start & (r_cnt == 3'd5);

  // Bytes shift in from the top, so after five shifts XL sits in r_buf[7:0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 3'd0;
      r_buf <= 40'd0;
    end else if (byte_valid) begin
      if (frame_start)         r_cnt <= 3'd1;
      else if (r_cnt == 3'd5)  r_cnt <= 3'd0;
      else                     r_cnt <= r_cnt + 3'd1;
      if (!w_byte_done) r_buf <= {byte_in, r_buf[39:8]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done  <= 1'b0;
      r_raw_x <= 16'd0;
      r_raw_y <= 16'd0;
      r_raw_z <= 16'd0;
    end else begin
      r_done <= w_byte_done;
      if (w_byte_done) begin
        r_raw_x <= r_buf[15:0];
        r_raw_y <= r_buf[31:16];
        r_raw_z <= {byte_in, r_buf[39:32]};
      end
    end
  end

  // A frame coinciding with cal_start is dropped entirely.
  assign w_take      = r_done & (r_state == ST_RUN) & ~cal_start;
  assign w_cal_frame = r_done & (r_state == ST_CAL) & ~cal_start;
  assign w_cal_last  = w_cal_frame & (r_cal_cnt == {CAL_LOG2{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre    <= '0;
      r_dt_cnt <= 16'd0;
    end else if (w_take) begin
      r_pre    <= '0;
      r_dt_cnt <= 16'd0;
    end else if (r_pre == PRE_MAX) begin
      r_pre <= '0;
      if (r_dt_cnt != 16'hFFFF) r_dt_cnt <= r_dt_cnt + 16'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign w_acc_x_next = r_acc_x + {{CAL_LOG2{r_raw_x[15]}}, r_raw_x};
  assign w_acc_y_next = r_acc_y + {{CAL_LOG2{r_raw_y[15]}}, r_raw_y};
  assign w_acc_z_next = r_acc_z + {{CAL_LOG2{r_raw_z[15]}}, r_raw_z};

  // Taking the upper 16 bits of the sum is the arithmetic shift by CAL_LOG2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_x   <= '0;
      r_acc_y   <= '0;
      r_acc_z   <= '0;
      r_cal_cnt <= '0;
      r_off_x   <= 16'd0;
      r_off_y   <= 16'd0;
      r_off_z   <= 16'd0;
      cal_done  <= 1'b0;
    end else if (cal_start) begin
      r_acc_x   <= '0;
      r_acc_y   <= '0;
      r_acc_z   <= '0;
      r_cal_cnt <= '0;
      cal_done  <= 1'b0;
    end else if (w_cal_frame) begin
      r_acc_x   <= w_acc_x_next;
      r_acc_y   <= w_acc_y_next;
      r_acc_z   <= w_acc_z_next;
      r_cal_cnt <= r_cal_cnt + {{(CAL_LOG2-1){1'b0}}, 1'b1};
      if (w_cal_last) begin
        r_off_x  <= w_acc_x_next[AW-1:CAL_LOG2];
        r_off_y  <= w_acc_y_next[AW-1:CAL_LOG2];
        r_off_z  <= w_acc_z_next[AW-1:CAL_LOG2];
        cal_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (cal_start)                             w_state_next = ST_CAL;
    else if (r_state == ST_CAL && w_cal_last)  w_state_next = ST_RUN;
  end

  assign w_cor_x = sat_sub(r_raw_x, r_off_x);
  assign w_cor_y = sat_sub(r_raw_y, r_off_y);
  assign w_cor_z = sat_sub(r_raw_z, r_off_z);

  // enable doubles as enable_q: the Integrator gets one cycle to raise bussy.
  assign w_issue = r_pend_valid & ~bussy & ~enable & ~cal_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_valid <= 1'b0;
      r_pend_x     <= 16'd0;
      r_pend_y     <= 16'd0;
      r_pend_z     <= 16'd0;
      r_pend_dt    <= 16'd0;
      acx          <= 16'd0;
      acy          <= 16'd0;
      acz          <= 16'd0;
      dt           <= 16'd0;
      enable       <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      enable <= w_issue;
      if (w_issue) begin
        acx <= r_pend_x;
        acy <= r_pend_y;
        acz <= r_pend_z;
        dt  <= r_pend_dt;
      end
      if (cal_start) begin
        r_pend_valid <= 1'b0;
        overrun      <= 1'b0;
      end else if (w_take) begin
        r_pend_valid <= 1'b1;
        r_pend_x     <= w_cor_x;
        r_pend_y     <= w_cor_y;
        r_pend_z     <= w_cor_z;
        if (r_pend_valid && !w_issue) begin
          r_pend_dt <= sat_add(r_pend_dt, r_dt_cnt);
          overrun   <= 1'b1;
        end else begin
          r_pend_dt <= r_dt_cnt;
        end
      end else if (w_issue) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

endmodule
